cc_hit_miss_dispatcher: RTL and testbench
=========================================

# cc_hit_miss_dispatcher

Final lookup-side stage of the cache controller, directly upstream of the data reorder unit. It accepts one tag-compare result per handshake. For each accepted result it pushes an ordering flag into the hit-flag FIFO. A hit also pushes the 512-bit line and its critical-word offset into the hit-data FIFO; a miss issues a critical-word-first AXI wrap-burst read (AR channel) to memory. It also bounds the number of outstanding misses so memory R data never outruns the flag stream.

## Interface
- MAX_OUTSTANDING, 2, maximum misses accepted but not yet completed (last R beat not yet consumed)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- tc_valid_i  in  1  lookup result valid
- tc_ready_o  out  1  lookup result accepted when high together with tc_valid_i
- tc_hit_i  in  1  1 = hit, 0 = miss
- tc_addr_i  in  32  request byte address
- tc_data_i  in  512  cache line (meaningful on hit only)
- hit_flag_fifo_afull_i  in  1  almost-full from flag FIFO (threshold depth-1)
- hit_flag_fifo_wren_o  out  1  flag push
- hit_flag_fifo_wdata_o  out  1  pushed flag (1 = hit)
- hit_data_fifo_afull_i  in  1  almost-full from data FIFO
- hit_data_fifo_wren_o  out  1  data push
- hit_data_fifo_wdata_o  out  515  {tc_addr_i[5:3], tc_data_i}
- mem_araddr_o  out  32  {tc_addr_i[31:3], 3'b000}
- mem_arlen_o  out  4  constant 7
- mem_arsize_o  out  3  constant 3 (8 bytes)
- mem_arburst_o  out  2  constant 2'b10 (WRAP)
- mem_arvalid_o  out  1  AR valid
- mem_arready_i  in  1  AR ready
- mem_rlast_beat_i  in  1  high for one cycle when the last beat of a miss burst is handshaken downstream (mem_rvalid & mem_rready & mem_rlast)

## Operation
- States: IDLE, AR_WAIT.
- tc_ready_o = (state==IDLE) & !hit_flag_fifo_afull_i & !hit_data_fifo_afull_i & (out_cnt < MAX_OUTSTANDING). It is independent of tc_hit_i and the payload.
- Accept in IDLE with a hit:
  - Next cycle: hit_flag_fifo_wren_o=1 with wdata 1, hit_data_fifo_wren_o=1 with the registered payload.
  - Both pulses last exactly one cycle. State stays IDLE.
- Accept in IDLE with a miss:
  - Next cycle: hit_flag_fifo_wren_o=1 with wdata 0, mem_arvalid_o=1 with registered mem_araddr_o.
  - State goes to AR_WAIT. out_cnt increments at acceptance.
- AR_WAIT:
  - mem_arvalid_o and mem_araddr_o are held stable until mem_arready_i.
  - The cycle mem_arvalid_o & mem_arready_i is true: arvalid drops next cycle and state returns to IDLE.
  - tc_ready_o=0 throughout AR_WAIT.
- out_cnt (width $clog2(MAX_OUTSTANDING+1)):
  - +1 on miss accept, -1 on mem_rlast_beat_i.
  - Both in the same cycle: unchanged.
  - Never wraps. mem_rlast_beat_i while out_cnt==0 is ignored (counter saturates at 0) and flagged by an assertion.
- Flag push order equals acceptance order. Memory returns bursts in AR order, so the downstream reorder unit sees consistent ordering.
- Required downstream FIFO depth is ≥2. The one-cycle-late push is covered by afull being asserted at depth-1.

## Timing
- Reset values:
  - tc_ready_o follows its equation, so it is 1 after reset with FIFOs not full.
  - All wren outputs 0, mem_arvalid_o 0.
  - mem_araddr_o 0, hit_data_fifo_wdata_o 0, hit_flag_fifo_wdata_o 0.
  - state IDLE, out_cnt 0.
- Latency: acceptance to FIFO push or arvalid is exactly 1 cycle. All outputs except tc_ready_o are registered.
- Back-to-back hits: one accepted per cycle while afull stays low.
- Misses: at most one per 2 cycles (accept, then AR_WAIT for ≥1 cycle).
- AXI rule: arvalid never depends combinationally on arready. Payload is stable while arvalid & !arready.
- Synchronous reset mid-AR_WAIT: arvalid drops on the next edge, and the pending request and out_cnt are discarded. Memory and FIFOs are reset together with this block.

## Structure
- Shared package cc_pkg: AXI burst encodings (BURST_WRAP=2'b10), CACHE_LINE_BITS=512, WORD_OFFSET_BITS=3, HIT_DATA_WIDTH=515, constant ARLEN_LINE=7, ARSIZE_8B=3.
- Single flat module; no sub-module needed. The FSM and counter are small.

## Test plan
- Single hit, addr=0x0000_1238, data pattern i→byte i → next cycle flag push 1, data push with wdata[514:512]=3'd7. No arvalid.
- Single miss, addr=0x0000_2010, arready held 0 for 3 cycles → flag push 0 next cycle. arvalid high 4 cycles with araddr=0x0000_2010, arlen=7, arburst=2'b10. tc_ready_o=0 until one cycle after the handshake.
- Three misses with no rlast, MAX_OUTSTANDING=2 → third miss not accepted (tc_ready_o=0). One mem_rlast_beat_i pulse → third accepted next eligible cycle.
- hit_data_fifo_afull_i=1 with tc_valid_i held → no acceptance and no pushes. Deassert afull → acceptance same cycle, push next cycle.
- Miss accept and mem_rlast_beat_i in the same cycle with out_cnt=1 → out_cnt stays 1.
- rst_n low during AR_WAIT → arvalid 0 and all outputs at reset values next edge. First transaction after reset behaves as in the single-hit scenario.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared cache-controller definitions.
// Holds AXI burst encodings, cache line geometry, the fixed AR burst shape used
// for critical-word-first line fills, and the dispatcher FSM state type.
package cc_pkg;

  localparam int CACHE_LINE_BITS  = 512;
  localparam int WORD_OFFSET_BITS = 3;
  localparam int HIT_DATA_WIDTH   = CACHE_LINE_BITS + WORD_OFFSET_BITS;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // A 64-byte line is 8 beats of 8 bytes.
  localparam logic [3:0] ARLEN_LINE = 4'd7;
  localparam logic [2:0] ARSIZE_8B  = 3'd3;

  typedef enum logic {
    ST_IDLE,
    ST_AR_WAIT
  } disp_state_e;

  // Word-aligned address of the critical word; the WRAP burst starts there.
  function automatic logic [31:0] cw_addr(input logic [31:0] addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/cc_hit_miss_dispatcher.sv
// Final lookup-side stage of the cache controller.
// Accepts one tag-compare result per handshake. Every accepted result pushes an
// ordering flag (1 = hit) into the hit-flag FIFO. Hits also push
// {critical word offset, line} into the hit-data FIFO; misses issue one
// critical-word-first WRAP read burst on the AXI AR channel. The number of
// misses still awaiting their last R beat is capped at MAX_OUTSTANDING.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   tc_valid_i/tc_ready_o           lookup result handshake
//   tc_hit_i, tc_addr_i, tc_data_i  lookup result payload
//   hit_flag_fifo_*                 ordering flag push (afull at depth-1)
//   hit_data_fifo_*                 hit line push (afull at depth-1)
//   mem_ar*                         AXI read address channel
//   mem_rlast_beat_i                last beat of a miss burst consumed
module cc_hit_miss_dispatcher
  import cc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tc_valid_i,
  output logic                      tc_ready_o,
  input  logic                      tc_hit_i,
  input  logic [31:0]               tc_addr_i,
  input  logic [CACHE_LINE_BITS-1:0] tc_data_i,
  input  logic                      hit_flag_fifo_afull_i,
  output logic                      hit_flag_fifo_wren_o,
  output logic                      hit_flag_fifo_wdata_o,
  input  logic                      hit_data_fifo_afull_i,
  output logic                      hit_data_fifo_wren_o,
  output logic [HIT_DATA_WIDTH-1:0] hit_data_fifo_wdata_o,
  output logic [31:0]               mem_araddr_o,
  output logic [3:0]                mem_arlen_o,
  output logic [2:0]                mem_arsize_o,
  output logic [1:0]                mem_arburst_o,
  output logic                      mem_arvalid_o,
  input  logic                      mem_arready_i,
  input  logic                      mem_rlast_beat_i
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  disp_state_e      state;
  logic [CNT_W-1:0] out_cnt;
  logic             accept;
  logic             miss_acc;
  logic             rlast_ok;

  // Byte offset within the critical word is irrelevant to an 8-byte beat.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^tc_addr_i[2:0];

  assign tc_ready_o = (state == ST_IDLE) && !hit_flag_fifo_afull_i &&
                      !hit_data_fifo_afull_i && (out_cnt < MAX_CNT);
  assign accept     = tc_valid_i && tc_ready_o;
  assign miss_acc   = accept && !tc_hit_i;
  // A stray rlast with nothing outstanding must not wrap the counter.
  assign rlast_ok   = mem_rlast_beat_i && (out_cnt != '0);

  assign mem_arlen_o   = ARLEN_LINE;
  assign mem_arsize_o  = ARSIZE_8B;
  assign mem_arburst_o = BURST_WRAP;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      out_cnt               <= '0;
      hit_flag_fifo_wren_o  <= 1'b0;
      hit_flag_fifo_wdata_o <= 1'b0;
      hit_data_fifo_wren_o  <= 1'b0;
      hit_data_fifo_wdata_o <= '0;
      mem_arvalid_o         <= 1'b0;
      mem_araddr_o          <= '0;
    end else begin
      hit_flag_fifo_wren_o <= accept;
      hit_data_fifo_wren_o <= accept && tc_hit_i;
      if (accept)
        hit_flag_fifo_wdata_o <= tc_hit_i;
      if (accept && tc_hit_i)
        hit_data_fifo_wdata_o <= {tc_addr_i[5:3], tc_data_i};

      if (miss_acc && !rlast_ok)
        out_cnt <= out_cnt + 1'b1;
      else if (!miss_acc && rlast_ok)
        out_cnt <= out_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (miss_acc) begin
            mem_arvalid_o <= 1'b1;
            mem_araddr_o  <= cw_addr(tc_addr_i);
            state         <= ST_AR_WAIT;
          end
        end
        ST_AR_WAIT: begin
          // Address stays put until the slave takes it.
          if (mem_arready_i) begin
            mem_arvalid_o <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rlast_without_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) !(mem_rlast_beat_i && out_cnt == '0));

endmodule

// File: tb/tb_cc_hit_miss_dispatcher.sv
module tb_cc_hit_miss_dispatcher;

  logic         clk;
  logic         rst_n;
  logic         tc_valid_i;
  logic         tc_ready_o;
  logic         tc_hit_i;
  logic [31:0]  tc_addr_i;
  logic [511:0] tc_data_i;
  logic         hit_flag_fifo_afull_i;
  logic         hit_flag_fifo_wren_o;
  logic         hit_flag_fifo_wdata_o;
  logic         hit_data_fifo_afull_i;
  logic         hit_data_fifo_wren_o;
  logic [514:0] hit_data_fifo_wdata_o;
  logic [31:0]  mem_araddr_o;
  logic [3:0]   mem_arlen_o;
  logic [2:0]   mem_arsize_o;
  logic [1:0]   mem_arburst_o;
  logic         mem_arvalid_o;
  logic         mem_arready_i;
  logic         mem_rlast_beat_i;

  cc_hit_miss_dispatcher #(.MAX_OUTSTANDING(2)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .tc_valid_i            (tc_valid_i),
    .tc_ready_o            (tc_ready_o),
    .tc_hit_i              (tc_hit_i),
    .tc_addr_i             (tc_addr_i),
    .tc_data_i             (tc_data_i),
    .hit_flag_fifo_afull_i (hit_flag_fifo_afull_i),
    .hit_flag_fifo_wren_o  (hit_flag_fifo_wren_o),
    .hit_flag_fifo_wdata_o (hit_flag_fifo_wdata_o),
    .hit_data_fifo_afull_i (hit_data_fifo_afull_i),
    .hit_data_fifo_wren_o  (hit_data_fifo_wren_o),
    .hit_data_fifo_wdata_o (hit_data_fifo_wdata_o),
    .mem_araddr_o          (mem_araddr_o),
    .mem_arlen_o           (mem_arlen_o),
    .mem_arsize_o          (mem_arsize_o),
    .mem_arburst_o         (mem_arburst_o),
    .mem_arvalid_o         (mem_arvalid_o),
    .mem_arready_i         (mem_arready_i),
    .mem_rlast_beat_i      (mem_rlast_beat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected pushes / AR requests in acceptance order.
  logic         q_flag[$];
  logic [514:0] q_data[$];
  logic [31:0]  q_ar[$];

  // Reference model: misses in flight and whether an AR is still unsent.
  int m_out;
  bit m_ar_pending;

  task automatic chk(input string name, input logic [514:0] act, input logic [514:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a push or AR.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hit_flag_fifo_wren_o) begin
        if (q_flag.size() == 0) chk("flag_unexpected", 515'(1), 515'(0));
        else chk("flag_wdata", 515'(hit_flag_fifo_wdata_o), 515'(q_flag.pop_front()));
      end
      if (hit_data_fifo_wren_o) begin
        if (q_data.size() == 0) chk("data_unexpected", 515'(1), 515'(0));
        else chk("data_wdata", hit_data_fifo_wdata_o, q_data.pop_front());
      end
      if (mem_arvalid_o) begin
        if (q_ar.size() == 0) chk("ar_unexpected", 515'(1), 515'(0));
        else begin
          chk("araddr", 515'(mem_araddr_o), 515'(q_ar[0]));
          if (mem_arready_i) begin
            chk("ar_shape", 515'({mem_arlen_o, mem_arsize_o, mem_arburst_o}),
                515'({4'd7, 3'd3, 2'b10}));
            void'(q_ar.pop_front());
          end
        end
      end
    end
  end

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic cycle(input logic v, input logic h, input logic [31:0] a,
                       input logic [511:0] d, input logic af, input logic df,
                       input logic ar, input logic rl);
    bit exp_ready, acc;
    tc_valid_i            = v;
    tc_hit_i              = h;
    tc_addr_i             = a;
    tc_data_i             = d;
    hit_flag_fifo_afull_i = af;
    hit_data_fifo_afull_i = df;
    mem_arready_i         = ar;
    mem_rlast_beat_i      = rl;
    exp_ready = !m_ar_pending && !af && !df && (m_out < 2);
    acc = v && exp_ready;
    if (acc) begin
      q_flag.push_back(h);
      if (h) q_data.push_back({a[5:3], d});
      else q_ar.push_back({a[31:3], 3'b000});
    end
    if (m_ar_pending && ar) m_ar_pending = 0;
    if (acc && !h) begin
      m_ar_pending = 1;
      m_out++;
    end
    if (rl && m_out > 0) m_out--;
    @(negedge clk);
    chk("tc_ready", 515'(tc_ready_o), 515'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tc_valid_i = 0; tc_hit_i = 0; tc_addr_i = '0; tc_data_i = '0;
    hit_flag_fifo_afull_i = 0; hit_data_fifo_afull_i = 0;
    mem_arready_i = 0; mem_rlast_beat_i = 0;
    repeat (2) @(posedge clk);
    #1;
    q_flag.delete(); q_data.delete(); q_ar.delete();
    m_out = 0; m_ar_pending = 0;
    @(negedge clk);
    chk("rst_ready", 515'(tc_ready_o), 515'(1));
    chk("rst_wren", 515'({hit_flag_fifo_wren_o, hit_data_fifo_wren_o, mem_arvalid_o}), 515'(0));
    chk("rst_araddr", 515'(mem_araddr_o), 515'(0));
    chk("rst_data_wdata", hit_data_fifo_wdata_o, 515'(0));
    chk("rst_flag_wdata", 515'(hit_flag_fifo_wdata_o), 515'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    logic [511:0] pat;
    int guard;
    for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'(i);

    do_reset();

    // Single hit with byte pattern, then single miss with arready held low.
    cycle(1, 1, 32'h0000_1238, pat, 0, 0, 0, 0);
    cycle(1, 0, 32'h0000_2010, '0, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 32'h0, '0, 0, 0, 0, 0);
    cycle(1, 1, 32'h40, rand_line(), 0, 0, 1, 0);
    cycle(0, 0, 32'h0, '0, 0, 0, 0, 0);

    // Saturate outstanding misses, then release one.
    repeat (8) cycle(1, 0, $urandom, '0, 0, 0, 1, 0);
    cycle(0, 0, 32'h0, '0, 0, 0, 1, 1);
    repeat (4) cycle(1, 0, $urandom, '0, 0, 0, 1, 0);
    // Miss accept coinciding with rlast: count must hold.
    cycle(0, 0, 32'h0, '0, 0, 0, 1, 1);
    cycle(1, 0, $urandom, '0, 0, 0, 1, 1);
    repeat (4) cycle(1, 0, $urandom, '0, 0, 0, 1, 0);
    while (m_out > 0) cycle(0, 0, 32'h0, '0, 0, 0, 1, 1);

    // Data FIFO almost full blocks acceptance, release accepts same cycle.
    repeat (3) cycle(1, 1, 32'h0000_0118, pat, 0, 1, 1, 0);
    cycle(1, 1, 32'h0000_0118, pat, 0, 0, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic rl;
      rl = (m_out > 0) && ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom, rand_line(),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) != 0, rl);
    end

    // Drain outstanding traffic.
    for (int n = 0; n < 10; n++) cycle(0, 0, 32'h0, '0, 0, 0, 1, m_out > 0);
    chk("flag_q_drained", 515'(q_flag.size()), 515'(0));
    chk("data_q_drained", 515'(q_data.size()), 515'(0));
    chk("ar_q_drained", 515'(q_ar.size()), 515'(0));

    // Reset while an AR is stalled.
    guard = 0;
    while (!m_ar_pending && guard < 20) begin
      cycle(1, 0, 32'h0000_3008, '0, 0, 0, 0, 0);
      guard++;
    end
    chk("reach_ar_wait", 515'(m_ar_pending), 515'(1));
    cycle(0, 0, 32'h0, '0, 0, 0, 0, 0);
    do_reset();
    cycle(1, 1, 32'h0000_1238, pat, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 32'h0, '0, 0, 0, 0, 0);
    chk("post_rst_flag_q", 515'(q_flag.size()), 515'(0));
    chk("post_rst_data_q", 515'(q_data.size()), 515'(0));
    chk("post_rst_ar_q", 515'(q_ar.size()), 515'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
